// File: rtl/viterbi_pkg.sv
// Shared constants and FSM encoding for the K=7 Viterbi traceback controller.
package viterbi_pkg;

    localparam int SW      = 6;
    localparam int NSTATES = 64;
    localparam int DEPTH   = 32;
    localparam int AW      = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_CHECK = 3'd2,
        ST_TRACE = 3'd3,
        ST_DRAIN = 3'd4
    } tb_state_e;

endpackage

// File: rtl/tb_bit_lifo.sv
// DEPTH x 1-bit stack that turns newest-first traceback bits into chronological order.
module tb_bit_lifo #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  logic i_pop,
    input  logic i_din,
    output logic o_empty,
    output logic o_full,
    output logic o_top
);
    logic [DEPTH-1:0] r_mem;
    logic [AW:0]      r_ptr;
    logic [AW:0]      w_topIdx;

    assign w_topIdx = r_ptr - 1'b1;
    assign o_empty  = (r_ptr == '0);
    assign o_full   = (r_ptr == (AW+1)'(DEPTH));
    assign o_top    = o_empty ? 1'b0 : r_mem[w_topIdx[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem <= '0;
            r_ptr <= '0;
        end else if (i_push && !o_full) begin
            r_mem[r_ptr[AW-1:0]] <= i_din;
            r_ptr                <= r_ptr + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_ptr <= r_ptr - 1'b1;
        end
    end

endmodule

// File: rtl/viterbi_traceback_ctrl.sv
// Block-mode traceback controller: fills pathMemory, traces the survivor path
// newest-first, and streams decoded bits out in chronological order.
module viterbi_traceback_ctrl
    import viterbi_pkg::*;
#(
    parameter int TERMINATED = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NSTATES-1:0] decisions,
    input  logic               decValid,
    output logic               decReady,
    input  logic [SW-1:0]      bestState,
    output logic               memEn,
    output logic               memWe,
    output logic [NSTATES-1:0] memWdata,
    output logic               memRe,
    input  logic [NSTATES-1:0] memOut,
    input  logic               memReady,
    output logic               bitOut,
    output logic               bitValid,
    input  logic               bitReady,
    output logic               busy,
    output logic               done,
    output logic               errFlag
);
    tb_state_e          r_state;
    logic [AW-1:0]      r_wrCnt;
    logic [AW-1:0]      r_rdCnt;
    logic [AW-1:0]      r_bitCnt;
    logic [SW-1:0]      r_tbState;
    logic               r_decReady;
    logic               r_memEn;
    logic               r_memWe;
    logic [NSTATES-1:0] r_memWdata;
    logic               r_memRe;
    logic               r_rdVld;
    logic               r_lastWr;
    logic               r_done;
    logic               r_errFlag;

    logic w_xfer, w_push, w_pop, w_empty, w_full, w_top, w_bitValid;

    assign w_xfer     = decValid & r_decReady;
    assign w_push     = (r_state == ST_TRACE) & r_rdVld & ~w_full;
    assign w_bitValid = (r_state == ST_DRAIN) & ~w_empty;
    assign w_pop      = w_bitValid & bitReady;

    tb_bit_lifo #(.DEPTH(DEPTH), .AW(AW)) u_lifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (r_tbState[SW-1]),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_top   (w_top)
    );

    assign decReady = r_decReady;
    assign memEn    = r_memEn;
    assign memWe    = r_memWe;
    assign memWdata = r_memWdata;
    assign memRe    = r_memRe;
    assign bitValid = w_bitValid;
    assign bitOut   = w_bitValid & w_top;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign errFlag  = r_errFlag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wrCnt    <= '0;
            r_rdCnt    <= '0;
            r_bitCnt   <= '0;
            r_tbState  <= '0;
            r_decReady <= 1'b0;
            r_memEn    <= 1'b0;
            r_memWe    <= 1'b0;
            r_memWdata <= '0;
            r_memRe    <= 1'b0;
            r_rdVld    <= 1'b0;
            r_lastWr   <= 1'b0;
            r_done     <= 1'b0;
            r_errFlag  <= 1'b0;
        end else begin
            r_memWe <= 1'b0;
            r_done  <= 1'b0;
            r_rdVld <= r_memRe;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_FILL;
                        r_memEn    <= 1'b1;
                        r_wrCnt    <= '0;
                        r_errFlag  <= 1'b0;
                        r_decReady <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (w_xfer) begin
                        r_memWe    <= 1'b1;
                        r_memWdata <= decisions;
                        r_wrCnt    <= r_wrCnt + 1'b1;
                        if (r_wrCnt == AW'(DEPTH-1)) begin
                            r_decReady <= 1'b0;
                            r_lastWr   <= 1'b1;
                            r_tbState  <= (TERMINATED != 0) ? '0 : bestState;
                        end
                    end
                    // one extra cycle so the final write lands before memReady is checked
                    if (r_lastWr) begin
                        r_lastWr <= 1'b0;
                        r_state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (memReady) begin
                        r_state  <= ST_TRACE;
                        r_memRe  <= 1'b1;
                        r_rdCnt  <= '0;
                        r_bitCnt <= '0;
                    end else begin
                        r_errFlag <= 1'b1;
                        r_memEn   <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_TRACE: begin
                    if (r_memRe) begin
                        r_rdCnt <= r_rdCnt + 1'b1;
                        if (r_rdCnt == AW'(DEPTH-1)) r_memRe <= 1'b0;
                    end
                    if (r_rdVld) begin
                        r_tbState <= {r_tbState[SW-2:0], memOut[r_tbState]};
                        r_bitCnt  <= r_bitCnt + 1'b1;
                        if (r_bitCnt == AW'(DEPTH-1)) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop) begin
                        r_bitCnt <= r_bitCnt + 1'b1;
                        if (r_bitCnt == AW'(DEPTH-1)) begin
                            r_done  <= 1'b1;
                            r_memEn <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_traceback_ctrl.sv
// Bench: terminated (g_dut[0]) and best-state (g_dut[1]) controllers driven in lockstep.
module tb_viterbi_traceback_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, decValid, bitReady, force_nr;
    logic [63:0] decisions;
    logic [5:0]  bestState;

    int total = 0;
    int bad   = 0;
    bit expq [2][$];
    logic [63:0] blk [32];

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        decReady, memEn, memWe, memRe, memReady, bitOut, bitValid, busy, done, errFlag;
        logic [63:0] memWdata, memOut;
        logic [63:0] mem [32];
        int          wcnt, rptr, ndone;
        bit          hold, hbit, e;

        viterbi_traceback_ctrl #(.TERMINATED(g == 0 ? 1 : 0)) u_dut (
            .clk(clk), .rst(rst), .start(start), .decisions(decisions), .decValid(decValid),
            .decReady(decReady), .bestState(bestState), .memEn(memEn), .memWe(memWe),
            .memWdata(memWdata), .memRe(memRe), .memOut(memOut), .memReady(memReady),
            .bitOut(bitOut), .bitValid(bitValid), .bitReady(bitReady), .busy(busy),
            .done(done), .errFlag(errFlag));

        // pathMemory model: append on write, read back newest-first, cleared while memEn=0
        always @(posedge clk or posedge rst) begin
            if (rst || !memEn) begin
                wcnt   <= 0;
                rptr   <= 31;
                memOut <= '0;
            end else begin
                if (memWe && wcnt < 32) begin
                    mem[wcnt] <= memWdata;
                    wcnt      <= wcnt + 1;
                end
                if (memRe && rptr >= 0) begin
                    memOut <= mem[rptr];
                    rptr   <= rptr - 1;
                end
            end
        end
        assign memReady = (wcnt == 32) && !force_nr;

        initial ndone = 0;
        always @(negedge clk) begin
            if (rst) begin
                hold = 0;
            end else begin
                if (done) ndone++;
                if (hold && bitValid) check($sformatf("bit_hold%0d", g), bitOut, hbit);
                hold = bitValid && !bitReady;
                hbit = bitOut;
                if (bitValid && bitReady) begin
                    if (expq[g].size() == 0) check($sformatf("extra_bit%0d", g), bitValid, 0);
                    else begin
                        e = expq[g].pop_front();
                        check($sformatf("bit%0d", g), bitOut, e);
                    end
                end
            end
        end
    end

    // chronological bit k is bit 5 of the survivor state at time k+1
    function automatic logic [31:0] ref_bits(input int s0);
        int s = s0;
        logic [31:0] r;
        for (int k = 31; k >= 0; k--) begin
            r[k] = s[5];
            s = ((s << 1) | int'(blk[k][s])) & 63;
        end
        return r;
    endfunction

    task automatic push_exp(input int best);
        logic [31:0] r0, r1;
        r0 = ref_bits(0);
        r1 = ref_bits(best);
        for (int j = 0; j < 32; j++) begin
            expq[0].push_back(r0[j]);
            expq[1].push_back(r1[j]);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_busy", g_dut[0].busy, 1);
        check("start_errclr", g_dut[0].errFlag, 0);
        @(posedge clk); #1;
    endtask

    task automatic feed(input int best, input bit bstart);
        int  i = 0, guard = 0;
        bit  xfer;
        bestState = 6'(best);
        while (i < 32 && guard < 500) begin
            decValid  = ($urandom_range(3) != 0);
            decisions = blk[i];
            start     = bstart && (i == 10);
            @(negedge clk);
            xfer = decValid && g_dut[0].decReady;
            @(posedge clk); #1;
            if (xfer) i++;
            guard++;
        end
        if (i < 32) check("feed_timeout", 64'(i), 32);
        start     = 1'b0;
        decValid  = 1'b0;
        bestState = 6'($urandom);
    endtask

    task automatic run_block(input int best, input int mode, input bit bstart);
        int cyc = 0, first = -1, nd0, nd1;
        bit s0 = 0, s1 = 0;
        nd0 = g_dut[0].ndone;
        nd1 = g_dut[1].ndone;
        push_exp(best);
        do_start();
        feed(best, bstart);
        bitReady = 1'b1;
        while (!(s0 && s1) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("memwe_c1", g_dut[0].memWe, 1);
                check("decready_c1", g_dut[0].decReady, 0);
            end
            if (first < 0 && g_dut[0].bitValid) first = cyc;
            if (g_dut[0].done) s0 = 1;
            if (g_dut[1].done) s1 = 1;
            @(posedge clk); #1;
            bitReady = (mode == 0) ? 1'b1 : (mode == 1) ? ~bitReady : 1'($urandom_range(1));
        end
        check("drain_done", {s0, s1}, 2'b11);
        bitReady = 1'b1;
        repeat (3) @(negedge clk);
        check("latency", 64'(first), 36);
        check("q0_empty", 64'(expq[0].size()), 0);
        check("q1_empty", 64'(expq[1].size()), 0);
        check("done_once0", 64'(g_dut[0].ndone - nd0), 1);
        check("done_once1", 64'(g_dut[1].ndone - nd1), 1);
        check("idle_after", {g_dut[0].busy, g_dut[0].errFlag}, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outs(input string nm);
        check({nm, "0"}, {g_dut[0].decReady, g_dut[0].memEn, g_dut[0].memWe, g_dut[0].memRe,
              g_dut[0].bitOut, g_dut[0].bitValid, g_dut[0].busy, g_dut[0].done,
              g_dut[0].errFlag, |g_dut[0].memWdata}, 0);
        check({nm, "1"}, {g_dut[1].decReady, g_dut[1].memEn, g_dut[1].memWe, g_dut[1].memRe,
              g_dut[1].bitOut, g_dut[1].bitValid, g_dut[1].busy, g_dut[1].done,
              g_dut[1].errFlag, |g_dut[1].memWdata}, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n, cnt;
        rst = 1'b1; start = 1'b0; decValid = 1'b0; decisions = '0;
        bestState = '0; bitReady = 1'b1; force_nr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("reset_outs");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // decValid while idle must not write
        decValid = 1'b1; decisions = '1; n = 0;
        repeat (5) begin
            @(negedge clk);
            if (g_dut[0].memWe || g_dut[0].decReady || g_dut[0].busy) n++;
            @(posedge clk); #1;
        end
        decValid = 1'b0;
        check("idle_decvalid", 64'(n), 0);

        for (int k = 0; k < 32; k++) blk[k] = '0;
        run_block(6'h3F, 0, 0);
        for (int k = 0; k < 32; k++) blk[k] = '1;
        run_block(int'($urandom_range(63)), 0, 1);
        run_block(int'($urandom_range(63)), 1, 0);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 32; k++) blk[k] = {$urandom, $urandom};
            run_block(int'($urandom_range(63)), 2, b[0]);
        end

        // memReady stuck low: error, back to idle, no bits
        force_nr = 1'b1;
        for (int k = 0; k < 32; k++) blk[k] = {$urandom, $urandom};
        do_start();
        feed(5, 0);
        @(negedge clk);
        check("err_memwe_c1", g_dut[0].memWe, 1);
        @(negedge clk);
        check("err_busy_c2", g_dut[0].busy, 1);
        @(negedge clk);
        check("err_flag_c3", {g_dut[0].errFlag, g_dut[1].errFlag}, 2'b11);
        check("err_idle_c3", {g_dut[0].busy, g_dut[1].busy}, 0);
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (g_dut[0].bitValid || g_dut[1].bitValid || g_dut[0].memRe) n++;
        end
        check("err_no_bits", 64'(n), 0);
        check("err_sticky", g_dut[0].errFlag, 1);
        force_nr = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 32; k++) blk[k] = {$urandom, $urandom};
        run_block(int'($urandom_range(63)), 2, 0);

        // asynchronous reset in the middle of traceback
        for (int k = 0; k < 32; k++) blk[k] = {$urandom, $urandom};
        do_start();
        feed(9, 0);
        cnt = 0; n = 0;
        while (cnt < 10 && n < 200) begin
            @(negedge clk);
            n++;
            if (g_dut[0].memRe) cnt++;
        end
        check("rst_reach_trace", 64'(cnt), 10);
        rst = 1'b1;
        #1;
        check_reset_outs("rst_async");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 32; k++) blk[k] = '0;
        run_block(int'($urandom_range(63)), 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
